game_state_ctrl: RTL

Round sequencer for the fighting-game display pipeline. Owns the game state (start / run / timeout / gameover) and the two-digit BCD round clock that the font overlay renders. It watches both players' health bytes and a start button, and produces the registered `graph_state`, `time_BCD` and winner flags consumed by the font and sprite logic.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_state_ctrl_if.sv | 27 ++
 rtl/game_state_ctrl_sec.sv | 33 +++
 rtl/game_state_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared encodings for the round sequencer and its consumers.
//   state_t  : game state, 0..3 matches the font overlay's encoding
//   winner_t : winner flags reported in TIMEOUT/GAMEOVER
//   HEALTH_W : width of one player's health byte
package game_pkg;

  localparam int unsigned HEALTH_W = 8;

  typedef enum logic [1:0] {
    ST_START    = 2'd0,
    ST_RUN      = 2'd1,
    ST_TIMEOUT  = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

endpackage

// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: bundle between the round sequencer and its environment.
//   start_btn, pause_btn : debounced button levels (to controller)
//   blood                : {P2 health, P1 health} (to controller)
//   graph_state, time_BCD, winner, round_end, freeze : controller outputs
// Modports: master = environment side, slave = game_state_ctrl.
interface game_state_ctrl_if;

  logic                             start_btn;
  logic                             pause_btn;
  logic [2*game_pkg::HEALTH_W-1:0]  blood;
  logic [1:0]                       graph_state;
  logic [7:0]                       time_BCD;
  logic [1:0]                       winner;
  logic                             round_end;
  logic                             freeze;

  modport master (
    output start_btn, pause_btn, blood,
    input  graph_state, time_BCD, winner, round_end, freeze
  );

  modport slave (
    input  start_btn, pause_btn, blood,
    output graph_state, time_BCD, winner, round_end, freeze
  );

endinterface

// File: rtl/game_state_ctrl_sec.sv
// sec_tick: round-clock prescaler.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the count (wins over en)
//   en       : count enable
//   tick     : one-cycle strobe while enabled and the count sits at TICK_DIV-1
module sec_tick #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == CNT_MAX) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: round sequencer (START/RUN/TIMEOUT/GAMEOVER) with a
// two-digit BCD round clock and winner reporting.
//   clk, rst : clock, asynchronous active-high reset
//   gs       : game_state_ctrl_if.slave (buttons, health in; state, clock,
//              winner, round_end pulse, freeze out; all outputs registered)
// Optional build macro: GAME_PAUSE_EN adds a pause toggle in RUN.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter logic [7:0]  TIME_INIT = 8'h99,
  parameter int unsigned HOLD_SECS = 3
) (
  input logic              clk,
  input logic              rst,
  game_state_ctrl_if.slave gs
);

  localparam int unsigned HOLD_W = (HOLD_SECS > 0) ? $clog2(HOLD_SECS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_SECS);

  state_t            state;
  winner_t           winner;
  logic [7:0]        time_bcd;
  logic              round_end;
  logic              freeze;
  logic [HOLD_W-1:0] hold_cnt;

  logic start_q, start_qq, start_press;
  logic tick, tick_en, state_chg;
  logic go_run, go_over, go_to, go_start, stay_run;
  logic in_end, hold_done, run_active, freeze_next;
  logic paused_next;
  logic p1_dead, p2_dead;
  winner_t dead_winner, cmp_winner;

  logic [HEALTH_W-1:0] p1_hp, p2_hp;
  assign p1_hp = gs.blood[HEALTH_W-1:0];
  assign p2_hp = gs.blood[2*HEALTH_W-1:HEALTH_W];

  assign start_press = start_q && !start_qq;

`ifdef GAME_PAUSE_EN
  logic pause_q, pause_qq, paused, pause_press;
  assign pause_press = pause_q && !pause_qq;
  assign run_active  = (state == ST_RUN) && !paused;
`else
  logic unused_pause_btn;
  assign unused_pause_btn = gs.pause_btn;
  assign run_active       = (state == ST_RUN);
`endif

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)           return 8'h00;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Transition decisions are combinational so the prescaler clear and the
  // freeze register can see the state change on the same edge it happens.
  always_comb begin
    p1_dead   = (p1_hp == '0);
    p2_dead   = (p2_hp == '0);
    in_end    = (state == ST_TIMEOUT) || (state == ST_GAMEOVER);
    hold_done = (hold_cnt == HOLD_MAX);

    go_run   = (state == ST_START) && start_press;
    go_over  = (state == ST_RUN) && (p1_dead || p2_dead);
    go_to    = (state == ST_RUN) && !go_over &&
               ((tick && time_bcd == 8'h01) || time_bcd == 8'h00);
    go_start = in_end && hold_done && start_press;
    stay_run = (state == ST_RUN) && !go_over && !go_to;

    state_chg = go_run || go_over || go_to || go_start;
    tick_en   = run_active || (in_end && !hold_done);

    if (p1_dead && p2_dead) dead_winner = WIN_DRAW;
    else if (p1_dead)       dead_winner = WIN_P2;
    else                    dead_winner = WIN_P1;

    if (p1_hp > p2_hp)      cmp_winner = WIN_P1;
    else if (p2_hp > p1_hp) cmp_winner = WIN_P2;
    else                    cmp_winner = WIN_DRAW;

`ifdef GAME_PAUSE_EN
    paused_next = stay_run ? (paused ^ pause_press) : 1'b0;
`else
    paused_next = 1'b0;
`endif
    freeze_next = !((go_run || stay_run) && !paused_next);
  end

  sec_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_chg),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_START;
      winner    <= WIN_NONE;
      time_bcd  <= TIME_INIT;
      round_end <= 1'b0;
      freeze    <= 1'b1;
      hold_cnt  <= '0;
      start_q   <= 1'b0;
      start_qq  <= 1'b0;
    end else begin
      start_q   <= gs.start_btn;
      start_qq  <= start_q;
      round_end <= 1'b0;
      freeze    <= freeze_next;

      if (state_chg)
        hold_cnt <= '0;
      else if (in_end && tick && !hold_done)
        hold_cnt <= hold_cnt + 1'b1;

      case (state)
        ST_START: begin
          time_bcd <= TIME_INIT;
          winner   <= WIN_NONE;
          if (go_run) state <= ST_RUN;
        end
        ST_RUN: begin
          if (go_over) begin
            state     <= ST_GAMEOVER;
            winner    <= dead_winner;
            round_end <= 1'b1;
          end else begin
            if (tick) time_bcd <= bcd_dec(time_bcd);
            if (go_to) begin
              state     <= ST_TIMEOUT;
              winner    <= cmp_winner;
              round_end <= 1'b1;
            end
          end
        end
        ST_TIMEOUT, ST_GAMEOVER: begin
          if (go_start) begin
            state    <= ST_START;
            winner   <= WIN_NONE;
            time_bcd <= TIME_INIT;
          end
        end
        default: state <= ST_START;
      endcase
    end
  end

`ifdef GAME_PAUSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_q  <= 1'b0;
      pause_qq <= 1'b0;
      paused   <= 1'b0;
    end else begin
      pause_q  <= gs.pause_btn;
      pause_qq <= pause_q;
      paused   <= paused_next;
    end
  end
`endif

  assign gs.graph_state = state;
  assign gs.winner      = winner;
  assign gs.time_BCD    = time_bcd;
  assign gs.round_end   = round_end;
  assign gs.freeze      = freeze;

endmodule
